// File: rtl/imm_extend_unit.sv
// imm_extend_unit: immediate extension (sign/zero/upper/branch) behind a 2-entry valid/ready buffer.
// Define IMM_EXT_STATS_EN to build the saturating negative-result counter (neg_count, stats_clear).
module imm_extend_unit #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  immediate,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] extended_imm,
  input  logic             stats_clear,
  output logic [15:0]      neg_count
);
  logic [1:0]       count;
  logic [OUT_W-1:0] tail, sext, res;
  logic             push, pop;
  assign sext      = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
  assign out_valid = count != 2'd0;
  assign in_ready  = count != 2'd2;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb
    res = mode == 2'd0 ? sext :
          mode == 2'd1 ? {{(OUT_W-IN_W){1'b0}}, immediate} :
          mode == 2'd2 ? {immediate, {(OUT_W-IN_W){1'b0}}} :
                         sext << 2;
  // extended_imm is the head register; it keeps the last popped value while empty
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count        <= 2'd0;
      extended_imm <= '0;
      tail         <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (push && (count == 2'd0 || (count == 2'd1 && pop)))
        extended_imm <= res;
      else if (pop && count == 2'd2)
        extended_imm <= tail;
      if (push && count == 2'd1 && !pop)
        tail <= res;
    end
`ifdef IMM_EXT_STATS_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      neg_count <= '0;
    else if (stats_clear)
      neg_count <= '0;
    else if (pop && extended_imm[OUT_W-1] && neg_count != 16'hFFFF)
      neg_count <= neg_count + 16'd1;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign neg_count          = '0;
`endif
endmodule
